dma_bus_master: RTL and testbench

- Bus master that copies a block of 32-bit words from one slave address range to another over the shared two-master bus.
- Sits directly upstream of the bus, connected to the m1 master port: its m_req/m_wr/m_addr/m_dout drive m1_req/m1_wr/m1_addr/m1_dout, and it receives m1_grant and m_din.
- Software or a top-level controller loads the source, destination and length, then pulses start. The block then arbitrates, moves the data word by word, releases the bus and reports done.

---
 rtl/dma_bus_master.sv | 205 ++++++++++++++++++++
 tb/tb_dma_bus_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_master.sv
// -----------------------------------------------------------------------------
// dma_bus_master
//
// Bus master that copies a block of 32-bit words from a source address range
// to a destination address range over the shared two-master bus (m1 port).
// A controller loads src_addr/dst_addr/length and pulses start; the block
// requests the bus, performs read/read-wait/write triplets word by word,
// drops the request and pulses done.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle start pulse, honoured only when idle
//   src_addr   in   [15:0] first source word address
//   dst_addr   in   [15:0] first destination word address
//   length     in   [LEN_W-1:0] number of words to copy
//   m_grant    in   bus grant for this master
//   m_din      in   [31:0] read data returned by the bus
//   m_req      out  bus request
//   m_wr       out  bus write enable (1 = write, 0 = read)
//   m_addr     out  [15:0] bus address
//   m_dout     out  [31:0] bus write data
//   busy       out  high from an accepted start until done
//   done       out  one-cycle completion pulse
//   dbg_state  out  [2:0] current FSM state (IDLE=0 REQ=1 RD=2 RDW=3 WR=4 DONE=5)
//
// Handshake: the bus is only considered ours in a cycle where m_req=1 and
// m_grant=1. A grant seen low in RD, RDW or WR abandons the current word and
// re-requests; the same word is restarted from RD once the grant returns.
// Read data is valid one cycle after the read address, i.e. in RDW.
// -----------------------------------------------------------------------------
module dma_bus_master #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             m_grant,
  input  logic [31:0]      m_din,
  output logic             m_req,
  output logic             m_wr,
  output logic [15:0]      m_addr,
  output logic [31:0]      m_dout,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_RDW  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        src_q, src_d;
  logic [15:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   i_q, i_d;
  logic [31:0]        buf_q, buf_d;
  logic [LEN_W-1:0]   i_inc;

  logic               m_req_q, m_req_d;
  logic               m_wr_q, m_wr_d;
  logic [15:0]        m_addr_q, m_addr_d;
  logic [31:0]        m_dout_q, m_dout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  assign i_inc = i_q + LEN_W'(1);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    buf_d   = buf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = length;
            i_d     = '0;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (m_grant) state_d = S_RD;
      end
      S_RD: begin
        state_d = m_grant ? S_RDW : S_REQ;
      end
      S_RDW: begin
        if (m_grant) begin
          buf_d   = m_din;
          state_d = S_WR;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WR: begin
        if (m_grant) begin
          i_d     = i_inc;
          state_d = (i_inc == len_q) ? S_DONE : S_RD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they are registered
  // and line up with the state they belong to.
  always_comb begin
    m_req_d  = 1'b0;
    m_wr_d   = 1'b0;
    m_addr_d = '0;
    m_dout_d = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_d)
      S_REQ: begin
        m_req_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_RD, S_RDW: begin
        m_req_d  = 1'b1;
        busy_d   = 1'b1;
        m_addr_d = src_d + 16'(i_d);
      end
      S_WR: begin
        m_req_d  = 1'b1;
        busy_d   = 1'b1;
        m_wr_d   = 1'b1;
        m_addr_d = dst_d + 16'(i_d);
        m_dout_d = buf_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      i_q      <= '0;
      buf_q    <= '0;
      m_req_q  <= 1'b0;
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_dout_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      i_q      <= i_d;
      buf_q    <= buf_d;
      m_req_q  <= m_req_d;
      m_wr_q   <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_dout_q <= m_dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_dout    = m_dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_bus_master.sv
// -----------------------------------------------------------------------------
// tb_dma_bus_master
//
// Bench for dma_bus_master. It plays the bus: a flat 64K-word slave memory
// with one-cycle read latency and a simple grant source in which the other
// master can hold the bus for a number of cycles and a single grant drop can
// be injected. The expected result of every copy comes from a word-by-word
// ascending copy on a reference memory; expected bus writes go into exp_q.
// -----------------------------------------------------------------------------
module tb_dma_bus_master;

  localparam int LEN_W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic             start = 1'b0;
  logic [15:0]      src_addr = '0;
  logic [15:0]      dst_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic             m_grant;
  logic [31:0]      m_din = '0;
  logic             m_req, m_wr, busy, done;
  logic [15:0]      m_addr;
  logic [31:0]      m_dout;
  logic [2:0]       dbg_state;

  dma_bus_master #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .m_grant   (m_grant),
    .m_din     (m_din),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- bus model
  int          cyc = 0;
  int          hold_until = 0;
  logic        kill = 1'b0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:65535];

  assign m_grant = m_req && (cyc >= hold_until) && !kill;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (m_req && m_grant && !m_wr) m_din <= mem[m_addr];
    if (m_req && m_grant && m_wr) mem[m_addr] <= m_dout;
  end

  // ---------------------------------------------------------------- scoreboard
  int compared = 0;
  int mismatched = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at each negedge while a transfer runs: every granted write must
  // match the next expected {addr, data}.
  task automatic sb_sample();
    logic [47:0] e;
    if (reset_n && m_req && m_grant && m_wr) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL bus_write: unexpected write addr=%h data=%h", m_addr, m_dout);
      end else begin
        e = exp_q.pop_front();
        if ({m_addr, m_dout} !== e) begin
          mismatched++;
          $display("FAIL bus_write: got %h/%h expected %h/%h", m_addr, m_dout, e[47:32], e[31:0]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic preload(input logic [15:0] base, input int n, input bit pattern);
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      v = pattern ? 32'(32'h11 * (k + 1)) : $urandom;
      @(negedge clk);
      pl_en = 1'b1;
      pl_addr = 16'(base + 16'(k));
      pl_data = v;
      ref_mem[16'(base + 16'(k))] = v;
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Reference behaviour: ascending word copy, each read seeing earlier writes.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [15:0] a, b;
    for (int k = 0; k < n; k++) begin
      a = 16'(s + 16'(k));
      b = 16'(d + 16'(k));
      exp_q.push_back({b, ref_mem[a]});
      ref_mem[b] = ref_mem[a];
    end
  endtask

  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                          input int h, input int kw, input int exp_cycles, input string tag);
    int cycles;
    bit bad_busy, bad_drive;
    int kill_state;
    model_copy(s, d, n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length = LEN_W'(n);
    start = 1'b1;
    hold_until = cyc + 1 + h;
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    length = LEN_W'($urandom);
    cycles = 1;
    bad_busy = 0;
    bad_drive = 0;
    kill_state = (kw >= 0) ? 0 : 3;
    while (!done && cycles < 2000) begin
      sb_sample();
      if (!busy) bad_busy = 1;
      if (!m_grant && !kill && (m_wr || m_addr != 16'h0 || m_dout != 32'h0 || !m_req))
        bad_drive = 1;
      if (kill_state == 0 && m_req && !m_wr && m_addr == 16'(s + 16'(kw))) begin
        kill_state = 1;
      end else if (kill_state == 1) begin
        kill = 1'b1;
        kill_state = 2;
      end else if (kill_state == 2) begin
        kill = 1'b0;
        kill_state = 3;
      end
      @(negedge clk);
      cycles++;
    end
    kill = 1'b0;
    check({tag, " done_seen"}, 48'(done), 48'd1);
    check({tag, " cycles"}, 48'(cycles), 48'(exp_cycles));
    check({tag, " busy_at_done"}, 48'(busy), 48'd0);
    check({tag, " req_at_done"}, 48'(m_req), 48'd0);
    check({tag, " busy_while_active"}, 48'(bad_busy), 48'd0);
    check({tag, " no_drive_ungranted"}, 48'(bad_drive), 48'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 48'(done), 48'd0);
    check({tag, " writes_all_seen"}, 48'(exp_q.size()), 48'd0);
    exp_q.delete();
    for (int k = 0; k < n; k++)
      check({tag, " dst_word"}, 48'(mem[16'(d + 16'(k))]), 48'(ref_mem[16'(d + 16'(k))]));
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    int          len;
    int          hold;
    int          kill_word;
    int          exp_cycles;
    bit          pattern;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, h, kw, guard;
    logic [15:0] s, d;

    vecs[0] = '{16'h0000, 16'h0100, 4, 0, -1, 14, 1'b1};  // basic 4-word copy
    vecs[1] = '{16'h0500, 16'h0600, 0, 0, -1, 1,  1'b0};  // zero length
    vecs[2] = '{16'h0040, 16'h0700, 4, 5, -1, 19, 1'b0};  // other master holds bus
    vecs[3] = '{16'h0040, 16'h0800, 3, 0, 1,  14, 1'b0};  // grant drop in RDW of word 1
    vecs[4] = '{16'hFFFF, 16'h0200, 2, 0, -1, 8,  1'b0};  // source address wrap
    vecs[5] = '{16'h1000, 16'h1002, 5, 0, -1, 17, 1'b0};  // overlapping ranges

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset m_req", 48'(m_req), 48'd0);
    check("reset m_wr", 48'(m_wr), 48'd0);
    check("reset m_addr", 48'(m_addr), 48'd0);
    check("reset m_dout", 48'(m_dout), 48'd0);
    check("reset busy", 48'(busy), 48'd0);
    check("reset done", 48'(done), 48'd0);
    check("reset state", 48'(dbg_state), 48'd0);
    reset_n = 1'b1;

    // Table-driven directed cases.
    foreach (vecs[v]) begin
      preload(vecs[v].src, vecs[v].len, vecs[v].pattern);
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].hold,
               vecs[v].kill_word, vecs[v].exp_cycles, $sformatf("vec%0d", v));
    end

    // Randomized copies with random contention and grant drops.
    for (int r = 0; r < 8; r++) begin
      s = $urandom;
      d = $urandom;
      n = $urandom_range(1, 10);
      h = $urandom_range(0, 3);
      kw = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      if (kw >= 0 && 16'(s + 16'(kw)) == 16'h0) kw = -1;
      preload(s, n, 1'b0);
      run_xfer(s, d, n, h, kw, 3 * n + 2 + h + ((kw >= 0) ? 3 : 0), $sformatf("rnd%0d", r));
    end

    // Reset asserted during WR of word 2.
    preload(16'h0900, 4, 1'b0);
    model_copy(16'h0900, 16'h0A00, 3);
    @(negedge clk);
    src_addr = 16'h0900;
    dst_addr = 16'h0A00;
    length = LEN_W'(4);
    start = 1'b1;
    hold_until = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(m_wr && m_addr == 16'h0A02) && guard < 200) begin
      sb_sample();
      @(negedge clk);
      guard++;
    end
    sb_sample();
    check("rst_mid reached_wr2", 48'(guard < 200), 48'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid m_req", 48'(m_req), 48'd0);
    check("rst_mid m_wr", 48'(m_wr), 48'd0);
    check("rst_mid busy", 48'(busy), 48'd0);
    check("rst_mid done", 48'(done), 48'd0);
    check("rst_mid state", 48'(dbg_state), 48'd0);
    check("rst_mid writes", 48'(exp_q.size()), 48'd0);
    exp_q.delete();
    // Word 2 was never committed; put the reference back in line with memory.
    ref_mem[16'h0A02] = mem[16'h0A02];
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid idle_after", 48'(dbg_state), 48'd0);
    check("rst_mid word0", 48'(mem[16'h0A00]), 48'(ref_mem[16'h0A00]));
    check("rst_mid word1", 48'(mem[16'h0A01]), 48'(ref_mem[16'h0A01]));
    preload(16'h0B00, 3, 1'b0);
    run_xfer(16'h0B00, 16'h0C00, 3, 0, -1, 11, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
